// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and line-fill state type for the I-cache refill path.
package ahb_pkg;

    localparam int AHB_ADDR_W = 32;
    localparam int AHB_DATA_W = 32;
    localparam int LINE_W     = 128;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } burst_type_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        FILL_IDLE,
        FILL_ADDR,
        FILL_BURST,
        FILL_LAST,
        FILL_DONE,
        FILL_ERR
    } fill_state_t;

    // Word slot within the line for a given beat of a critical-word-first wrap.
    function automatic logic [1:0] wrap_word(input logic [1:0] start_word, input logic [1:0] beat);
        return start_word + beat;
    endfunction

endpackage

// File: rtl/line_fill_engine_wrap4_addr_gen.sv
// WRAP4 address generator: holds the line base fixed and wraps the word index modulo 4.
module wrap4_addr_gen #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:2] word_addr,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [1:0]            word_idx
);

    logic [ADDR_WIDTH-1:4] line_base;
    logic [1:0]            idx;

    // Load the critical word address, then step the word index once per accepted address phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base <= '0;
            idx       <= 2'd0;
        end else if (load) begin
            line_base <= word_addr[ADDR_WIDTH-1:4];
            idx       <= word_addr[3:2];
        end else if (advance) begin
            idx <= idx + 2'd1;
        end
    end

    assign addr     = {line_base, idx, 2'b00};
    assign word_idx = idx;

endmodule

// File: rtl/line_fill_engine.sv
// I-cache line refill master: critical-word-first WRAP4 read burst on AHB-Lite,
// early critical word return, then the assembled line with its tag address.
module line_fill_engine
    import ahb_pkg::*;
#(
    parameter int CACHE_LINE = LINE_W,
    parameter int ADDR_WIDTH = AHB_ADDR_W,
    parameter int DATA_WIDTH = AHB_DATA_W
) (
    input  logic                  hclk,
    input  logic                  hrstn,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  crit_valid,
    output logic [DATA_WIDTH-1:0] crit_data,
    output logic                  fill_valid,
    output logic [CACHE_LINE-1:0] fill_line,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic                  fill_err,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic [2:0]            hburst,
    output logic [2:0]            hsize,
    output logic                  hwrite,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    fill_state_t state;
    htrans_t     htrans_r;
    logic [1:0]  beat_cnt;
    logic [1:0]  crit_idx;
    logic [1:0]  word_idx;
    logic [1:0]  data_idx;
    logic        load;
    logic        advance;
    logic        in_data_phase;
    logic        req_addr_lsb_unused;

    // The byte offset within the word is irrelevant for word fetches.
    assign req_addr_lsb_unused = ^req_addr[1:0];

    // Address-phase control for the generator: load on acceptance, step on each
    // accepted address phase except the fourth, and never on an ERROR cycle.
    always_comb begin
        load    = (state == FILL_IDLE) && req_valid && req_ready;
        advance = 1'b0;
        if (hready && !hresp) begin
            if (state == FILL_ADDR)
                advance = 1'b1;
            else if (state == FILL_BURST && beat_cnt != 2'd2)
                advance = 1'b1;
        end
    end

    assign in_data_phase = (state == FILL_BURST) || (state == FILL_LAST);
    assign data_idx      = wrap_word(crit_idx, beat_cnt);

    // The first ERROR cycle cancels the pending address phase immediately.
    assign htrans = (in_data_phase && hresp && !hready) ? HTRANS_IDLE : htrans_r;
    assign hburst = BURST_WRAP4;
    assign hsize  = HSIZE_WORD;
    assign hwrite = 1'b0;

    wrap4_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (hclk),
        .rst_n    (hrstn),
        .load     (load),
        .word_addr(req_addr[ADDR_WIDTH-1:2]),
        .advance  (advance),
        .addr     (haddr),
        .word_idx (word_idx)
    );

    // Fill sequencer: address/data phase tracking, beat capture and result pulses.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state      <= FILL_IDLE;
            htrans_r   <= HTRANS_IDLE;
            req_ready  <= 1'b1;
            beat_cnt   <= 2'd0;
            crit_idx   <= 2'd0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
            fill_valid <= 1'b0;
            fill_err   <= 1'b0;
            fill_line  <= '0;
            fill_addr  <= '0;
        end else begin
            crit_valid <= 1'b0;
            fill_valid <= 1'b0;
            fill_err   <= 1'b0;
            case (state)
                FILL_IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= FILL_ADDR;
                        htrans_r  <= HTRANS_NONSEQ;
                        req_ready <= 1'b0;
                        beat_cnt  <= 2'd0;
                        fill_addr <= {req_addr[ADDR_WIDTH-1:4], 4'b0000};
                    end
                end
                FILL_ADDR: begin
                    if (hready) begin
                        state    <= FILL_BURST;
                        htrans_r <= HTRANS_SEQ;
                        crit_idx <= word_idx;
                    end
                end
                FILL_BURST, FILL_LAST: begin
                    if (hresp) begin
                        htrans_r <= HTRANS_IDLE;
                        if (hready) begin
                            state    <= FILL_ERR;
                            fill_err <= 1'b1;
                        end
                    end else if (hready) begin
                        for (int k = 0; k < 4; k++) begin
                            if (data_idx == 2'(k))
                                fill_line[k*DATA_WIDTH +: DATA_WIDTH] <= hrdata;
                        end
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd0) begin
                            crit_valid <= 1'b1;
                            crit_data  <= hrdata;
                        end
                        if (state == FILL_BURST && beat_cnt == 2'd2) begin
                            state    <= FILL_LAST;
                            htrans_r <= HTRANS_IDLE;
                        end
                        if (state == FILL_LAST) begin
                            state      <= FILL_DONE;
                            fill_valid <= 1'b1;
                        end
                    end
                end
                FILL_DONE, FILL_ERR: begin
                    state     <= FILL_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= FILL_IDLE;
                    htrans_r  <= HTRANS_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_engine.sv
// Bench for line_fill_engine: AHB slave with scripted waits/errors plus a
// transaction-level reference of the expected burst, line and pulse timing.
module tb_line_fill_engine;

    logic         hclk = 1'b0;
    logic         hrstn;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         fill_valid;
    logic [127:0] fill_line;
    logic [31:0]  fill_addr;
    logic         fill_err;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic [2:0]   hsize;
    logic         hwrite;
    logic [31:0]  hrdata;
    logic         hready;
    logic         hresp;

    always #5 hclk = ~hclk;

    line_fill_engine dut (
        .hclk      (hclk),
        .hrstn     (hrstn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .crit_valid(crit_valid),
        .crit_data (crit_data),
        .fill_valid(fill_valid),
        .fill_line (fill_line),
        .fill_addr (fill_addr),
        .fill_err  (fill_err),
        .haddr     (haddr),
        .htrans    (htrans),
        .hburst    (hburst),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Memory contents: upper half is the address, lower half its complement, xor a salt.
    function automatic logic [31:0] mem(input logic [31:0] a, input logic [31:0] salt);
        return {a[15:0], ~a[15:0]} ^ salt;
    endfunction

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    // Per-request configuration chosen by the stimulus
    int          cfg_waits[4];
    int          cfg_err_beat = -1;
    logic [31:0] cfg_salt     = '0;

    // Reference model state
    bit           m_ready = 1'b1;
    bit           m_busy  = 1'b0;
    logic [31:0]  m_base, m_crit_addr, m_salt;
    int           m_waits[4];
    int           m_err_beat;
    int           m_acc_cyc;
    logic [31:0]  aq[$];
    logic [127:0] exp_line;
    bit           first_ph, aborted, dp_act;
    logic [31:0]  dp_addr;
    int           dp_beat, beats, wait_left, err_stage;
    bit           e_crit = 0, e_fill = 0, e_err = 0;
    bit           n_crit, n_fill, n_err, nxt_ready, addr_acc;
    logic         nxt_hready = 1'b1, nxt_hresp = 1'b0;
    logic [31:0]  nxt_hrdata = '0;

    // Observations for directed checks
    int           acc_count = 0, fill_count = 0, err_count = 0, crit_count = 0;
    int           last_acc_cyc, last_fill_cyc, last_err_cyc, last_crit_cyc;
    logic [127:0] last_line;
    logic [31:0]  last_crit, last_faddr;
    logic [31:0]  addr_log[$];

    // Compare DUT against the reference each cycle, then advance the reference
    // across the coming edge and plan the slave's response for the next cycle.
    always @(negedge hclk) begin
        if (!hrstn) begin
            check("rst_req_ready", req_ready, 1'b1);
            check("rst_htrans", htrans, 2'b00);
            check("rst_haddr", haddr, 32'h0);
            check("rst_pulses", {crit_valid, fill_valid, fill_err}, 3'b000);
            check("rst_data", {fill_line, crit_data, fill_addr} == '0, 1'b1);
            m_ready = 1'b1; m_busy = 1'b0; aq.delete(); dp_act = 1'b0;
            e_crit = 0; e_fill = 0; e_err = 0; aborted = 0; beats = 0;
            wait_left = 0; err_stage = 0;
            nxt_hready = 1'b1; nxt_hresp = 1'b0; nxt_hrdata = '0;
        end else begin
            check("req_ready", req_ready, m_ready);
            check("crit_valid", crit_valid, e_crit);
            check("fill_valid", fill_valid, e_fill);
            check("fill_err", fill_err, e_err);
            check("hburst", hburst, 3'b010);
            check("hsize", hsize, 3'b010);
            check("hwrite", hwrite, 1'b0);
            if (e_crit) begin
                check("crit_data", crit_data, mem(m_crit_addr, m_salt));
                check("crit_time", cyc, m_acc_cyc + 2 + m_waits[0]);
                crit_count++; last_crit_cyc = cyc; last_crit = crit_data;
            end
            if (e_fill) begin
                check("fill_line", fill_line, exp_line);
                check("fill_addr", fill_addr, m_base);
                check("fill_time", cyc, m_acc_cyc + 5 + m_waits[0] + m_waits[1] + m_waits[2] + m_waits[3]);
                fill_count++; last_fill_cyc = cyc; last_line = fill_line; last_faddr = fill_addr;
            end
            if (e_err) begin
                err_count++; last_err_cyc = cyc;
            end
            if (m_busy && aq.size() != 0 && !aborted && !(dp_act && hresp)) begin
                check("htrans", htrans, first_ph ? 2'b10 : 2'b11);
                check("haddr", haddr, aq[0]);
            end else begin
                check("htrans_idle", htrans, 2'b00);
            end

            n_crit = 0; n_fill = 0; n_err = 0;
            nxt_ready = m_ready;
            if (e_fill || e_err) nxt_ready = 1'b1;
            addr_acc = m_busy && hready && !hresp && !aborted && aq.size() != 0;
            if (dp_act && hready) begin
                if (hresp) begin
                    n_err = 1; m_busy = 0; aq.delete();
                end else begin
                    if (beats == 0) n_crit = 1;
                    beats++;
                    if (beats == 4) begin
                        n_fill = 1; m_busy = 0;
                    end
                end
                dp_act = 0;
            end
            if (dp_act && hresp && !hready) aborted = 1;
            if (addr_acc) begin
                addr_log.push_back(haddr);
                dp_addr   = aq.pop_front();
                first_ph  = 0;
                dp_act    = 1;
                wait_left = m_waits[dp_beat];
                err_stage = (dp_beat == m_err_beat) ? 1 : 0;
                dp_beat++;
            end
            if (m_ready && req_valid) begin
                nxt_ready   = 0;
                m_busy      = 1;
                m_base      = {req_addr[31:4], 4'h0};
                m_crit_addr = {req_addr[31:2], 2'b00};
                m_salt      = cfg_salt;
                m_waits     = cfg_waits;
                m_err_beat  = cfg_err_beat;
                m_acc_cyc   = cyc + 1;
                last_acc_cyc = m_acc_cyc;
                aq.delete();
                addr_log.delete();
                for (int k = 0; k < 4; k++) begin
                    logic [1:0] w;
                    w = req_addr[3:2] + 2'(k);
                    aq.push_back({m_base[31:4], w, 2'b00});
                    exp_line[32*k +: 32] = mem(m_base + 32'(4*k), cfg_salt);
                end
                first_ph = 1; beats = 0; aborted = 0; dp_beat = 0;
                acc_count++;
            end
            m_ready = nxt_ready;
            e_crit = n_crit; e_fill = n_fill; e_err = n_err;

            if (dp_act) begin
                if (wait_left > 0) begin
                    nxt_hready = 0; nxt_hresp = 0; nxt_hrdata = $urandom; wait_left--;
                end else if (err_stage == 1) begin
                    nxt_hready = 0; nxt_hresp = 1; nxt_hrdata = $urandom; err_stage = 2;
                end else if (err_stage == 2) begin
                    nxt_hready = 1; nxt_hresp = 1; nxt_hrdata = $urandom; err_stage = 0;
                end else begin
                    nxt_hready = 1; nxt_hresp = 0; nxt_hrdata = mem(dp_addr, m_salt);
                end
            end else begin
                nxt_hready = 1; nxt_hresp = 0; nxt_hrdata = $urandom;
            end
        end
    end

    // Slave drive: apply the planned response just after each rising edge.
    initial begin
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        forever begin
            @(posedge hclk);
            #1;
            hready = nxt_hready; hresp = nxt_hresp; hrdata = nxt_hrdata;
        end
    end

    task automatic wait_accept(input int old);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge hclk);
            if (acc_count > old) begin
                ok = 1;
                break;
            end
        end
        #1;
        check("accept_timeout", ok, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge hclk);
            #1;
            if (m_ready && !m_busy) begin
                ok = 1;
                break;
            end
        end
        check("idle_timeout", ok, 1'b1);
    endtask

    task automatic do_req(input logic [31:0] a, input int w0, input int w1, input int w2,
                          input int w3, input int eb, input logic [31:0] salt);
        int old;
        cfg_waits[0] = w0; cfg_waits[1] = w1; cfg_waits[2] = w2; cfg_waits[3] = w3;
        cfg_err_beat = eb; cfg_salt = salt;
        old = acc_count;
        req_addr = a; req_valid = 1'b1;
        wait_accept(old);
        req_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int old_fill, old_err, old_crit, old_acc;
        hrstn = 1'b0; req_valid = 1'b0; req_addr = '0;
        repeat (3) @(posedge hclk);
        #1 hrstn = 1'b1;
        repeat (2) @(posedge hclk);
        #1;

        // Zero-wait critical-word-first fill from 0x1008
        do_req(32'h0000_1008, 0, 0, 0, 0, -1, 32'h0);
        check("t1_line", last_line, 128'h100CEFF3_1008EFF7_1004EFFB_1000EFFF);
        check("t1_faddr", last_faddr, 32'h0000_1000);
        check("t1_crit", last_crit, 32'h1008EFF7);
        check("t1_crit_lat", last_crit_cyc - last_acc_cyc, 2);
        check("t1_fill_lat", last_fill_cyc - last_acc_cyc, 5);
        check("t1_haddr0", addr_log[0], 32'h1008);
        check("t1_haddr1", addr_log[1], 32'h100C);
        check("t1_haddr2", addr_log[2], 32'h1000);
        check("t1_haddr3", addr_log[3], 32'h1004);

        // Aligned fill with two wait states on beat 2
        do_req(32'h0000_2000, 0, 2, 0, 0, -1, 32'h0);
        check("t2_line", last_line, 128'h200CDFF3_2008DFF7_2004DFFB_2000DFFF);
        check("t2_fill_lat", last_fill_cyc - last_acc_cyc, 7);

        // ERROR on beat 3
        old_fill = fill_count; old_err = err_count; old_crit = crit_count;
        do_req(32'h0000_3004, 0, 0, 0, 0, 2, 32'h0);
        check("t3_no_fill", fill_count, old_fill);
        check("t3_err_cnt", err_count, old_err + 1);
        check("t3_crit_kept", crit_count, old_crit + 1);
        check("t3_err_lat", last_err_cyc - last_acc_cyc, 5);

        // Request held through a busy fill, address changed to 0x4000
        cfg_waits = '{0, 0, 0, 0}; cfg_err_beat = -1; cfg_salt = 32'h0;
        old_acc = acc_count;
        req_addr = 32'h0000_600C; req_valid = 1'b1;
        wait_accept(old_acc);
        req_addr = 32'h0000_4000;
        old_acc = acc_count;
        wait_accept(old_acc);
        req_valid = 1'b0;
        check("t4_accept_gap", last_acc_cyc - last_fill_cyc, 2);
        wait_idle();
        check("t4_first_haddr", addr_log[0], 32'h0000_4000);
        check("t4_faddr", last_faddr, 32'h0000_4000);

        // Reset after beat 2 of a fill
        old_fill = fill_count; old_err = err_count;
        cfg_waits = '{0, 0, 0, 0}; cfg_err_beat = -1;
        old_acc = acc_count;
        req_addr = 32'h0000_7008; req_valid = 1'b1;
        wait_accept(old_acc);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && beats < 2; i++) @(posedge hclk);
        #1 hrstn = 1'b0;
        #1;
        check("t5_ready_async", req_ready, 1'b1);
        check("t5_htrans_async", htrans, 2'b00);
        repeat (2) @(posedge hclk);
        #1 hrstn = 1'b1;
        repeat (8) @(posedge hclk);
        #1;
        check("t5_no_fill", fill_count, old_fill);
        check("t5_no_err", err_count, old_err);
        do_req(32'h0000_7008, 0, 0, 0, 0, -1, 32'h0);
        check("t5_refill", fill_count, old_fill + 1);

        // Critical word timing from 0x500C
        do_req(32'h0000_500C, 0, 0, 0, 0, -1, 32'h0);
        check("t6_crit", last_crit, 32'h500CAFF3);
        check("t6_crit_lat", last_crit_cyc - last_acc_cyc, 2);
        check("t6_fill_lat", last_fill_cyc - last_acc_cyc, 5);

        // Randomized fills with wait states, errors and salted memory
        for (int n = 0; n < 40; n++) begin
            int w[4];
            int eb;
            for (int k = 0; k < 4; k++)
                w[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_req($urandom, w[0], w[1], w[2], w[3], eb, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge hclk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
